// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexing scan controller for a 4-digit 7-segment display.
//   Each digit owns a slot of DIV cycles. The first BLANK cycles of every
//   slot keep all anodes off so the previous digit's segments cannot ghost
//   onto the new digit. After that the digit's anode is driven low, unless
//   its blank_mask bit is set.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | scan disabled, all anodes off, cnt cleared, sel held
//   BLNK  | start-of-slot blanking window, all anodes off
//   ON    | selected digit lit (unless masked) until the slot ends
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   en          scan enable; 0 = dark, position held
//   blank_mask  bit i = 1 keeps digit i dark during its slot
//   sel         digit select for the downstream digit mux
//   an          anode enables, active-low
//   tick        1-cycle pulse when sel advances
//   frame       1-cycle pulse when sel wraps 3 -> 0 (coincides with tick)
module display_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] blank_mask,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       tick,
  output logic       frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK - 1);
  localparam logic [CW-1:0] CNT_SLOT_END  = CW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BLNK = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Anode pattern for a lit digit. A set mask bit keeps the digit dark.
  function automatic logic [3:0] lit_an(input logic [1:0] s, input logic [3:0] m);
    logic [3:0] r;
    r = 4'b1111;
    if (!m[s]) r[s] = 1'b0;
    return r;
  endfunction

  // an is computed from the next state/sel so it lines up with them in the
  // same cycle; the mask is therefore sampled one cycle ahead of its effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel   <= 2'd0;
      an    <= 4'b1111;
      tick  <= 1'b0;
      frame <= 1'b0;
    end else begin
      tick  <= 1'b0;
      frame <= 1'b0;
      if (!en) begin
        // Disable wins over any slot-end event in the same cycle.
        state <= ST_IDLE;
        cnt   <= '0;
        an    <= 4'b1111;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_BLNK;
            cnt   <= '0;
            an    <= 4'b1111;
          end
          ST_BLNK: begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_BLANK_END) begin
              state <= ST_ON;
              an    <= lit_an(sel, blank_mask);
            end else begin
              an    <= 4'b1111;
            end
          end
          ST_ON: begin
            if (cnt == CNT_SLOT_END) begin
              state <= ST_BLNK;
              cnt   <= '0;
              sel   <= sel + 2'd1;
              tick  <= 1'b1;
              frame <= (sel == 2'd3);
              an    <= 4'b1111;
            end else begin
              cnt   <= cnt + CW'(1);
              an    <= lit_an(sel, blank_mask);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            an    <= 4'b1111;
          end
        endcase
      end
    end
  end

endmodule
